uart_byte_display: RTL and testbench
====================================

UART_BYTE_DISPLAY -- requirements
Module: uart_byte_display

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 25000000, meaning the number of clocks with no new byte before the display blanks (1 s at 25 MHz); legal range >= 2.
REQ-002 SHALL have port i_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_RX_DV, input, 1 bit: one-cycle strobe meaning i_RX_Byte is valid.
REQ-005 SHALL have port i_RX_Byte, input, 8 bits: received UART data byte.
REQ-006 SHALL have port o_Upper_Nibble, output, 4 bits: held byte [7:4], feeding the tens-digit 7-segment encoder.
REQ-007 SHALL have port o_Lower_Nibble, output, 4 bits: held byte [3:0], feeding the ones-digit 7-segment encoder.
REQ-008 SHALL have port o_Display_En, output, 1 bit: 1 = digits lit; 0 = downstream forces segments off.
REQ-009 SHALL have port o_New_Byte, output, 1 bit: one-cycle pulse the cycle after a byte is captured.
REQ-010 SHALL have port o_Byte_Count, output, 8 bits: count of bytes received since reset.

Function
REQ-011 SHALL implement a three-state FSM: EMPTY (no byte since reset), SHOW (byte displayed, timer running), BLANK (timed out, byte retained).
REQ-012 SHALL, on i_RX_DV=1 in any state, capture i_RX_Byte and go to SHOW; nibble outputs, o_New_Byte=1 and o_Display_En=1 are all visible one clock after the strobe cycle (latency 1).
REQ-013 SHALL, on entry to SHOW or re-capture in SHOW, load the timer with TIMEOUT_CLKS-1 and decrement it once per clock while in SHOW with no strobe.
REQ-014 SHALL move SHOW->BLANK on the clock where the timer is 0 and i_RX_DV=0, so o_Display_En falls exactly TIMEOUT_CLKS clocks after the capture edge.
REQ-015 SHALL give priority to i_RX_DV over expiry: a strobe on the expiry cycle stays in SHOW and reloads the timer.
REQ-016 SHALL hold o_Display_En=0 in EMPTY and BLANK and 1 in SHOW; nibbles retain the last captured byte in BLANK.
REQ-017 SHALL increment o_Byte_Count by 1 per strobe, wrapping 255->0 without saturation.
REQ-018 SHALL size the timer as $clog2(TIMEOUT_CLKS) bits with no overflow.
REQ-019 SHALL treat back-to-back strobes (consecutive cycles) as separate bytes: each one is captured and counted, and o_New_Byte stays high for each.

Reset
REQ-020 SHALL, when i_Rst=1, set state=EMPTY, nibbles=4'h0, o_Display_En=0, o_New_Byte=0, o_Byte_Count=0 and timer=0 on the next edge.
REQ-021 SHALL give reset priority over a simultaneous i_RX_DV: the byte is dropped and not counted.
REQ-022 SHALL, on reset mid-SHOW, abandon the timer; the next strobe starts a full TIMEOUT_CLKS period.

Configuration
REQ-023 SHALL provide macro UART_BYTE_DISPLAY_TIMEOUT_EN: when defined, REQ-013/014 apply; when undefined, the timer and BLANK state are not built, SHOW is terminal until reset, and o_Display_En=1 from the first capture onward.

Structure
REQ-024 SHALL place the FSM state encoding (EMPTY=2'd0, SHOW=2'd1, BLANK=2'd2) and the default timeout constant in shared package uart_display_pkg.
REQ-025 SHALL implement the timer as sub-module display_timeout_timer (load, enable, expired), instantiated only under UART_BYTE_DISPLAY_TIMEOUT_EN.

Verification (TIMEOUT_CLKS=16 in bench unless stated)
REQ-026 SHALL test reset then a strobe with 8'hA7: next cycle Upper=4'hA, Lower=4'h7, En=1, New_Byte=1 for exactly 1 cycle, Count=1.
REQ-027 SHALL test a single byte 8'h3C followed by no activity: En stays 1 for 16 clocks, drops on clock 16 after capture, and nibbles remain 3/C.
REQ-028 SHALL test a strobe 8'h55 on the exact expiry cycle: En never drops, and it drops 16 clocks after that strobe.
REQ-029 SHALL test 256 back-to-back strobes: Count returns to 0, New_Byte is high 256 consecutive cycles, and the last byte is displayed.
REQ-030 SHALL test i_Rst asserted together with a strobe of 8'hFF: outputs are 0, Count=0 and En=0; with the macro undefined, 8'h12 keeps En=1 for 1000 idle clocks.

Source files
------------

// File: rtl/uart_display_pkg.sv
// uart_display_pkg: FSM state encoding and default timeout shared by the byte display.
package uart_display_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } display_state_t;
  localparam int DEFAULT_TIMEOUT_CLKS = 25000000;
endpackage

// File: rtl/display_timeout_timer.sv
// display_timeout_timer: down-counter loaded with TIMEOUT_CLKS-1, expired while it sits at zero.
module display_timeout_timer #(
  parameter int TIMEOUT_CLKS = uart_display_pkg::DEFAULT_TIMEOUT_CLKS
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Load,
  input  logic i_En,
  output logic o_Expired
);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] r_cnt;
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_cnt <= '0;
    else if (i_Load) r_cnt <= TW'(TIMEOUT_CLKS - 1);
    else if (i_En && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_Expired = r_cnt == '0;
endmodule

// File: rtl/uart_byte_display.sv
// uart_byte_display: holds the last UART byte for two hex digits; blanking after
// TIMEOUT_CLKS idle clocks is built only with UART_BYTE_DISPLAY_TIMEOUT_EN defined.
module uart_byte_display
  import uart_display_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [3:0] o_Upper_Nibble,
  output logic [3:0] o_Lower_Nibble,
  output logic       o_Display_En,
  output logic       o_New_Byte,
  output logic [7:0] o_Byte_Count
);
  display_state_t r_state, w_next;
  logic [7:0] r_byte, r_count;
  logic       r_new;
  logic       w_expired;
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 2");
  end
`ifdef UART_BYTE_DISPLAY_TIMEOUT_EN
  display_timeout_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Load    (i_RX_DV),
    .i_En      (r_state == SHOW),
    .o_Expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  // a strobe always wins over expiry, so the timer reload and SHOW coincide
  always_comb begin
    w_next = r_state;
    if (i_RX_DV) w_next = SHOW;
    else if (r_state == SHOW && w_expired) w_next = BLANK;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= EMPTY;
      r_byte  <= '0;
      r_count <= '0;
      r_new   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_new   <= i_RX_DV;
      if (i_RX_DV) begin
        r_byte  <= i_RX_Byte;
        r_count <= r_count + 8'd1;
      end
    end
  end
  assign o_Upper_Nibble = r_byte[7:4];
  assign o_Lower_Nibble = r_byte[3:0];
  assign o_Display_En   = r_state == SHOW;
  assign o_New_Byte     = r_new;
  assign o_Byte_Count   = r_count;
endmodule

// File: tb/tb_uart_byte_display.sv
// tb_uart_byte_display: directed and random strobes checked every cycle against an idle-count model.
module tb_uart_byte_display;
  localparam int T = 16;
`ifdef UART_BYTE_DISPLAY_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       i_Rst = 1'b1, i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = '0;
  logic [3:0] o_Upper_Nibble, o_Lower_Nibble;
  logic       o_Display_En, o_New_Byte;
  logic [7:0] o_Byte_Count;
  int n_checks = 0, n_errors = 0;
  string phase = "init";
  logic [7:0] m_byte = '0, m_cnt = '0;
  logic m_new = 1'b0, m_shown = 1'b0;
  int m_idle = 0;
  int new_run = 0;

  uart_byte_display #(.TIMEOUT_CLKS(T)) dut (
    .i_Clk          (clk),
    .i_Rst          (i_Rst),
    .i_RX_DV        (i_RX_DV),
    .i_RX_Byte      (i_RX_Byte),
    .o_Upper_Nibble (o_Upper_Nibble),
    .o_Lower_Nibble (o_Lower_Nibble),
    .o_Display_En   (o_Display_En),
    .o_New_Byte     (o_New_Byte),
    .o_Byte_Count   (o_Byte_Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  function automatic logic exp_en();
    return m_shown && (!TIMEOUT_ON || m_idle < T);
  endfunction

  task automatic step(input logic rst, input logic dv, input logic [7:0] b);
    i_Rst = rst;
    i_RX_DV = dv;
    i_RX_Byte = b;
    @(posedge clk);
    if (rst) begin
      m_byte = '0; m_cnt = '0; m_new = 1'b0; m_shown = 1'b0; m_idle = 0;
    end else if (dv) begin
      m_byte = b; m_cnt = m_cnt + 8'd1; m_new = 1'b1; m_shown = 1'b1; m_idle = 0;
    end else begin
      m_new = 1'b0;
      if (m_shown && m_idle < T) m_idle++;
    end
    #1;
    check("upper", o_Upper_Nibble, m_byte[7:4]);
    check("lower", o_Lower_Nibble, m_byte[3:0]);
    check("en", o_Display_En, exp_en());
    check("new", o_New_Byte, m_new);
    check("count", o_Byte_Count, m_cnt);
    new_run = o_New_Byte ? new_run + 1 : 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    phase = "reset";
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("reset_en", o_Display_En, 1'b0);
    idle(3);

    phase = "a7";
    step(1'b0, 1'b1, 8'hA7);
    check("a7_byte", {o_Upper_Nibble, o_Lower_Nibble}, 8'hA7);
    idle(1);
    check("a7_pulse_once", o_New_Byte, 1'b0);

    phase = "timeout";
    step(1'b0, 1'b1, 8'h3C);
    idle(T - 2);
    check("en_before_expiry", o_Display_En, 1'b1);
    idle(1);
    check("en_at_clock_T_minus_1", o_Display_En, 1'b1);
    idle(1);
    check("en_at_clock_T", o_Display_En, !TIMEOUT_ON);
    check("nibbles_kept", {o_Upper_Nibble, o_Lower_Nibble}, 8'h3C);
    idle(4);

    phase = "expiry_strobe";
    step(1'b0, 1'b1, 8'h3C);
    idle(T - 1);
    step(1'b0, 1'b1, 8'h55);
    check("en_held", o_Display_En, 1'b1);
    idle(T - 1);
    check("en_before_reexpiry", o_Display_En, 1'b1);
    idle(1);
    check("en_reexpiry", o_Display_En, !TIMEOUT_ON);
    idle(2);

    phase = "b2b";
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 256; k++) step(1'b0, 1'b1, 8'($urandom));
    check("b2b_count_wrap", o_Byte_Count, 8'd0);
    check("b2b_new_run", new_run, 256);
    idle(1);
    check("b2b_new_end", o_New_Byte, 1'b0);

    phase = "rst_vs_dv";
    step(1'b0, 1'b1, 8'h99);
    step(1'b1, 1'b1, 8'hFF);
    check("rst_byte", {o_Upper_Nibble, o_Lower_Nibble}, 8'h00);
    check("rst_count", o_Byte_Count, 8'd0);
    check("rst_en", o_Display_En, 1'b0);

    phase = "reset_mid_show";
    step(1'b0, 1'b1, 8'h21);
    idle(5);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h34);
    idle(T);

    phase = "long_idle";
    step(1'b0, 1'b1, 8'h12);
    idle(1000);
    check("long_idle_en", o_Display_En, !TIMEOUT_ON);
    check("long_idle_byte", {o_Upper_Nibble, o_Lower_Nibble}, 8'h12);

    phase = "random";
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
